// File: rtl/kb_pkg.sv
// Shared PS/2 keyboard command codes, LED bit positions and controller state encoding.
// Pure declarations, no latency or flow control of its own.
package kb_pkg;

  localparam logic [7:0] KB_CMD_SET_LED = 8'hED;
  localparam logic [7:0] KB_ACK         = 8'hFA;
  localparam logic [7:0] KB_RESEND      = 8'hFE;

  localparam int LED_CAPS   = 2;
  localparam int LED_NUM    = 1;
  localparam int LED_SCROLL = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_WAIT_ACK1 = 3'd2,
    ST_ARG       = 3'd3,
    ST_WAIT_ACK2 = 3'd4
  } state_t;

  function automatic logic [7:0] led_mask(input logic [2:0] leds);
    return {5'b0, leds[LED_CAPS], leds[LED_NUM], leds[LED_SCROLL]};
  endfunction

  function automatic logic is_ack_or_resend(input logic [7:0] b);
    return (b == KB_ACK) || (b == KB_RESEND);
  endfunction

endpackage

// File: rtl/kb_led_ctrl_if.sv
// Byte, LED and transmitter signals between the LED controller and its host-side neighbours.
// Wires only; the transmitter side backpressures through i_tx_ready.
interface kb_led_ctrl_if;
  logic [2:0] i_leds;
  logic       i_byte_en;
  logic [7:0] i_byte;
  logic       i_tx_ready;
  logic       o_tx_en;
  logic [7:0] o_tx_byte;
  logic       o_byte_en;
  logic [7:0] o_byte;
  logic       o_busy;
  logic       o_err;
  logic [2:0] o_leds_applied;

  modport master (
    output i_leds, i_byte_en, i_byte, i_tx_ready,
    input  o_tx_en, o_tx_byte, o_byte_en, o_byte, o_busy, o_err, o_leds_applied
  );

  modport slave (
    input  i_leds, i_byte_en, i_byte, i_tx_ready,
    output o_tx_en, o_tx_byte, o_byte_en, o_byte, o_busy, o_err, o_leds_applied
  );
endinterface

// File: rtl/kb_timeout_counter.sv
// Ack timeout counter: o_expired is combinational once the count reaches LIMIT-1 while enabled.
// Saturates at LIMIT-1 (no wrap); i_clr restarts the count from zero.
module kb_timeout_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 100
) (
  input  logic clk,
  input  logic i_sclr,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (i_sclr || i_clr) begin
      count <= '0;
    end else if (i_en && (count != LAST)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign o_expired = i_en && (count == LAST);

endmodule

// File: rtl/kb_led_ctrl.sv
// Keeps keyboard lock LEDs in sync via the ED/mask/ack exchange and filters acks out of the byte stream.
// Filtered bytes and tx requests are registered (1 cycle); transmit waits on i_tx_ready without timing out.
module kb_led_ctrl
  import kb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int MAX_RETRY      = 3
) (
  input logic          clk,
  input logic          i_sclr,
  kb_led_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t        state_q, state_d;
  logic [2:0]    target_q, target_d;
  logic [2:0]    failed_q, failed_d;
  logic [2:0]    applied_q, applied_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          byte_en_q, byte_en_d;
  logic [7:0]    byte_q;
  logic          in_wait, timer_clr, expired, got_ack, got_resend;

  assign in_wait    = (state_q == ST_WAIT_ACK1) || (state_q == ST_WAIT_ACK2);
  assign got_ack    = bus.i_byte_en && (bus.i_byte == KB_ACK);
  assign got_resend = bus.i_byte_en && (bus.i_byte == KB_RESEND);

  kb_timeout_counter #(
    .WIDTH (TW),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .i_sclr    (i_sclr),
    .i_clr     (timer_clr),
    .i_en      (in_wait),
    .o_expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    failed_d  = failed_q;
    applied_d = applied_q;
    retry_d   = retry_q;
    err_d     = err_q;
    tx_en_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    timer_clr = 1'b0;
    byte_en_d = bus.i_byte_en && !(in_wait && is_ack_or_resend(bus.i_byte));

    case (state_q)
      ST_IDLE: begin
        // A target that already failed is not retried until the request changes.
        if ((bus.i_leds != applied_q) && !(err_q && (bus.i_leds == failed_q))) begin
          target_d = bus.i_leds;
          retry_d  = '0;
          state_d  = ST_CMD;
        end
      end
      ST_CMD, ST_ARG: begin
        if (bus.i_tx_ready) begin
          tx_en_d   = 1'b1;
          timer_clr = 1'b1;
          if (state_q == ST_CMD) begin
            tx_byte_d = KB_CMD_SET_LED;
            state_d   = ST_WAIT_ACK1;
          end else begin
            tx_byte_d = led_mask(target_q);
            state_d   = ST_WAIT_ACK2;
          end
        end
      end
      ST_WAIT_ACK1, ST_WAIT_ACK2: begin
        if (got_ack) begin
          if (state_q == ST_WAIT_ACK1) begin
            retry_d = '0;
            state_d = ST_ARG;
          end else begin
            applied_d = target_q;
            err_d     = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (got_resend || (!bus.i_byte_en && expired)) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            err_d    = 1'b1;
            failed_d = target_q;
            state_d  = ST_IDLE;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = (state_q == ST_WAIT_ACK1) ? ST_CMD : ST_ARG;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      failed_q  <= '0;
      applied_q <= '0;
      retry_q   <= '0;
      err_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_byte_q <= '0;
      byte_en_q <= 1'b0;
      byte_q    <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      failed_q  <= failed_d;
      applied_q <= applied_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      tx_en_q   <= tx_en_d;
      tx_byte_q <= tx_byte_d;
      byte_en_q <= byte_en_d;
      if (byte_en_d) begin
        byte_q <= bus.i_byte;
      end
    end
  end

  assign bus.o_tx_en        = tx_en_q;
  assign bus.o_tx_byte      = tx_byte_q;
  assign bus.o_byte_en      = byte_en_q;
  assign bus.o_byte         = byte_q;
  assign bus.o_busy         = (state_q != ST_IDLE);
  assign bus.o_err          = err_q;
  assign bus.o_leds_applied = applied_q;

endmodule

// File: tb/tb_kb_led_ctrl.sv
// Directed bench: scoreboard queues of expected tx and pass-through bytes plus an applied-LED model,
// checked on every falling edge, with literal checks at key points of each scenario.
module tb_kb_led_ctrl;
  import kb_pkg::*;

  localparam int TO = 100;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic i_sclr;
  kb_led_ctrl_if bus();

  kb_led_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (MR)
  ) dut (
    .clk    (clk),
    .i_sclr (i_sclr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tx_cnt  = 0;
  int tx_cyc[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [2:0] m_applied = 3'b000;
  logic       chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the scoreboard model.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("leds_applied_model", {29'b0, bus.o_leds_applied}, {29'b0, m_applied});
      if (bus.o_tx_en === 1'b1) begin
        tx_cnt++;
        tx_cyc.push_back(cyc);
        if (exp_tx.size() == 0) begin
          check("unexpected_tx", {24'b0, bus.o_tx_byte}, 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", {24'b0, bus.o_tx_byte}, {24'b0, exp_tx.pop_front()});
        end
      end
      if (bus.o_byte_en === 1'b1) begin
        if (exp_rx.size() == 0) begin
          check("unexpected_byte", {24'b0, bus.o_byte}, 32'hFFFF_FFFF);
        end else begin
          check("pass_byte", {24'b0, bus.o_byte}, {24'b0, exp_rx.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic pass);
    @(posedge clk);
    #1;
    bus.i_byte_en = 1'b1;
    bus.i_byte    = b;
    if (pass) exp_rx.push_back(b);
    @(posedge clk);
    #1;
    bus.i_byte_en = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int i;
    i = 0;
    while (tx_cnt < n && i < 400) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("tx_arrived", {31'b0, tx_cnt >= n}, 32'd1);
  endtask

  // Full successful update from IDLE: ED, ack, mask, ack.
  task automatic run_update(input logic [2:0] leds);
    bus.i_leds = leds;
    exp_tx.push_back(KB_CMD_SET_LED);
    wait_tx(tx_cnt + 1);
    send_byte(KB_ACK, 1'b0);
    exp_tx.push_back({5'b0, leds});
    wait_tx(tx_cnt + 1);
    send_byte(KB_ACK, 1'b0);
    m_applied = leds;
  endtask

  initial begin
    int base;
    int i;
    i_sclr         = 1'b1;
    bus.i_leds     = 3'b000;
    bus.i_byte_en  = 1'b0;
    bus.i_byte     = 8'h00;
    bus.i_tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_en", {31'b0, bus.o_tx_en}, 32'd0);
    check("rst_byte_en", {31'b0, bus.o_byte_en}, 32'd0);
    check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    check("rst_err", {31'b0, bus.o_err}, 32'd0);
    check("rst_applied", {29'b0, bus.o_leds_applied}, 32'd0);
    i_sclr = 1'b0;
    chk_en = 1'b1;

    // Basic caps-lock update; acks never reach the byte output.
    bus.i_leds = 3'b100;
    exp_tx.push_back(8'hED);
    wait_tx(1);
    check("s1_busy", {31'b0, bus.o_busy}, 32'd1);
    send_byte(8'hFA, 1'b0);
    exp_tx.push_back(8'h04);
    wait_tx(2);
    send_byte(8'hFA, 1'b0);
    m_applied = 3'b100;
    check("s1_applied", {29'b0, bus.o_leds_applied}, 32'h4);
    check("s1_busy_done", {31'b0, bus.o_busy}, 32'd0);
    check("s1_err", {31'b0, bus.o_err}, 32'd0);

    // Non-ack byte in WAIT_ACK1 passes with one cycle latency.
    bus.i_leds = 3'b001;
    exp_tx.push_back(8'hED);
    wait_tx(tx_cnt + 1);
    send_byte(8'h1C, 1'b1);
    check("s2_pass_en", {31'b0, bus.o_byte_en}, 32'd1);
    check("s2_pass_byte", {24'b0, bus.o_byte}, 32'h1C);
    send_byte(8'hFA, 1'b0);
    exp_tx.push_back(8'h01);
    wait_tx(tx_cnt + 1);
    send_byte(8'hFA, 1'b0);
    m_applied = 3'b001;

    // Two resends of the mask byte, then success.
    base = tx_cnt;
    bus.i_leds = 3'b100;
    exp_tx.push_back(8'hED);
    wait_tx(base + 1);
    send_byte(8'hFA, 1'b0);
    exp_tx.push_back(8'h04);
    wait_tx(base + 2);
    send_byte(8'hFE, 1'b0);
    exp_tx.push_back(8'h04);
    wait_tx(base + 3);
    send_byte(8'hFE, 1'b0);
    exp_tx.push_back(8'h04);
    wait_tx(base + 4);
    send_byte(8'hFA, 1'b0);
    m_applied = 3'b100;
    check("s3_tx_total", tx_cnt - base, 32'd4);
    check("s3_applied", {29'b0, bus.o_leds_applied}, 32'h4);

    // Timeouts exhaust retries on ED.
    i_sclr = 1'b1;
    bus.i_leds = 3'b000;
    @(posedge clk);
    #1;
    i_sclr = 1'b0;
    m_applied = 3'b000;
    base = tx_cnt;
    bus.i_leds = 3'b001;
    repeat (3) exp_tx.push_back(8'hED);
    wait_tx(base + 3);
    check("s4_gap1", tx_cyc[base + 1] - tx_cyc[base], TO + 1);
    check("s4_gap2", tx_cyc[base + 2] - tx_cyc[base + 1], TO + 1);
    i = 0;
    while (bus.o_err !== 1'b1 && i < 200) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("s4_err", {31'b0, bus.o_err}, 32'd1);
    check("s4_busy", {31'b0, bus.o_busy}, 32'd0);
    check("s4_applied", {29'b0, bus.o_leds_applied}, 32'd0);
    repeat (300) @(posedge clk);
    #1;
    check("s4_no_retry", tx_cnt - base, 32'd3);
    run_update(3'b010);
    check("s4_err_clear", {31'b0, bus.o_err}, 32'd0);
    check("s4_recover", {29'b0, bus.o_leds_applied}, 32'h2);

    // Transmitter not ready: no tx and no timeout while waiting in CMD.
    base = tx_cnt;
    bus.i_tx_ready = 1'b0;
    bus.i_leds = 3'b011;
    repeat (500) @(posedge clk);
    #1;
    check("s5_no_tx", tx_cnt - base, 32'd0);
    check("s5_busy", {31'b0, bus.o_busy}, 32'd1);
    check("s5_no_err", {31'b0, bus.o_err}, 32'd0);
    exp_tx.push_back(8'hED);
    bus.i_tx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("s5_tx_en", {31'b0, bus.o_tx_en}, 32'd1);
    check("s5_tx_byte", {24'b0, bus.o_tx_byte}, 32'hED);
    wait_tx(base + 1);
    send_byte(8'hFA, 1'b0);
    exp_tx.push_back(8'h03);
    wait_tx(base + 2);
    send_byte(8'hFA, 1'b0);
    m_applied = 3'b011;

    // Request changes mid-sequence: latched target finishes first.
    base = tx_cnt;
    bus.i_leds = 3'b100;
    exp_tx.push_back(8'hED);
    wait_tx(base + 1);
    bus.i_leds = 3'b110;
    send_byte(8'hFA, 1'b0);
    exp_tx.push_back(8'h04);
    wait_tx(base + 2);
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h06);
    send_byte(8'hFA, 1'b0);
    m_applied = 3'b100;
    check("s6_first", {29'b0, bus.o_leds_applied}, 32'h4);
    wait_tx(base + 3);
    send_byte(8'hFA, 1'b0);
    wait_tx(base + 4);
    send_byte(8'hFA, 1'b0);
    m_applied = 3'b110;
    check("s6_second", {29'b0, bus.o_leds_applied}, 32'h6);

    // Reset in WAIT_ACK2, then restart right after release.
    base = tx_cnt;
    bus.i_leds = 3'b001;
    exp_tx.push_back(8'hED);
    wait_tx(base + 1);
    send_byte(8'hFA, 1'b0);
    exp_tx.push_back(8'h01);
    wait_tx(base + 2);
    i_sclr = 1'b1;
    @(posedge clk);
    #1;
    m_applied = 3'b000;
    check("s7_busy", {31'b0, bus.o_busy}, 32'd0);
    check("s7_applied", {29'b0, bus.o_leds_applied}, 32'd0);
    i_sclr = 1'b0;
    exp_tx.push_back(8'hED);
    @(posedge clk);
    #1;
    check("s7_restart", {31'b0, bus.o_busy}, 32'd1);
    wait_tx(base + 3);
    send_byte(8'hFA, 1'b0);
    exp_tx.push_back(8'h01);
    wait_tx(base + 4);
    send_byte(8'hFA, 1'b0);
    m_applied = 3'b001;

    // Ack/resend bytes pass through when no sequence is waiting.
    send_byte(8'hFA, 1'b1);
    check("idle_fa_pass", {24'b0, bus.o_byte}, 32'hFA);
    send_byte(8'hFE, 1'b1);
    check("idle_fe_pass", {24'b0, bus.o_byte}, 32'hFE);

    repeat (5) @(posedge clk);
    #1;
    check("tx_queue_empty", exp_tx.size(), 32'd0);
    check("rx_queue_empty", exp_rx.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/kb_led_ctrl.md
Name: kb_led_ctrl

Overview:
Host-side command controller that keeps the keyboard's Caps/Num/Scroll Lock LEDs in sync with the lock state tracked in the design. It sits between `recv` (received bytes) and the PS/2 host transmitter. On any LED change it sequences the Set-LED command (0xED, ack, LED mask, ack), retries on resend or timeout, and consumes ack/resend bytes. All other received bytes pass through to `keydown` and `shift_key`.

Parameters:
TIMEOUT_CYCLES, 2500000, clk cycles to wait for an ack (50 ms at 50 MHz)
MAX_RETRY, 3, resends allowed per byte before giving up

Ports:
clk  input  1  system clock
i_sclr  input  1  synchronous active-high reset
i_leds  input  3  requested LEDs: [2]=caps, [1]=num, [0]=scroll
i_byte_en  input  1  one-cycle strobe from recv
i_byte  input  8  byte from recv
i_tx_ready  input  1  transmitter idle and able to accept a byte
o_tx_en  output  1  one-cycle request to transmit o_tx_byte
o_tx_byte  output  8  byte to transmit
o_byte_en  output  1  filtered byte strobe to keydown/shift_key
o_byte  output  8  filtered byte
o_busy  output  1  sequence in progress
o_err  output  1  last update failed after retries
o_leds_applied  output  3  LED state the keyboard has acknowledged

Behaviour:
- Single clock domain (clk). i_sclr is synchronous and active-high.
- Reset values:
  - All outputs are 0; o_leds_applied = 3'b000.
  - State is IDLE; retry count and timer are 0.
- States: IDLE, CMD, WAIT_ACK1, ARG, WAIT_ACK2.
- IDLE:
  - Start when i_leds != o_leds_applied, unless o_err=1 and i_leds == failed_target.
  - On start: target <= i_leds, retry <= 0, go to CMD.
- CMD / ARG: wait for i_tx_ready=1. On that cycle, register o_tx_en=1 for exactly one cycle with o_tx_byte:
  - CMD: 8'hED, then go to WAIT_ACK1.
  - ARG: {5'b0, target}, then go to WAIT_ACK2.
  - No timeout applies while waiting for i_tx_ready.
- WAIT_ACKn: timer clears on entry and increments each cycle. Timeout fires when timer == TIMEOUT_CYCLES-1.
  - i_byte_en with 8'hFA:
    - WAIT_ACK1 goes to ARG with retry <= 0.
    - WAIT_ACK2 sets o_leds_applied <= target and o_err <= 0, then goes to IDLE.
  - i_byte_en with 8'hFE, or timeout:
    - If retry == MAX_RETRY: o_err <= 1, failed_target <= target, go to IDLE; o_leds_applied is unchanged.
    - Otherwise retry++ and return to the state that sent the last byte (CMD or ARG).
  - i_byte_en with any other byte: pass it through; state and timer are unaffected.
  - A byte strobe and timeout in the same cycle: the byte wins.
- Filtering:
  - o_byte_en and o_byte are registered (1-cycle latency).
  - FA/FE are suppressed only in WAIT_ACK1/2. In every other state, every byte passes, including FA/FE.
- i_leds changing mid-sequence does not affect the latched target. It is re-evaluated in IDLE after completion.
- o_busy = (state != IDLE), decoded from the state register.
- Widths:
  - Timer width is $clog2(TIMEOUT_CYCLES+1).
  - Retry width is $clog2(MAX_RETRY+1).
  - No wrap: the timer stops at timeout.
- Reset mid-operation returns to IDLE with o_leds_applied=0. A non-zero i_leds restarts a sequence on the first cycle after i_sclr deasserts.

Decomposition:
- Shared package kb_pkg:
  - KB_CMD_SET_LED=8'hED, KB_ACK=8'hFA, KB_RESEND=8'hFE.
  - LED bit indices.
  - State encoding localparams.
- One natural sub-module, kb_timeout_counter (params WIDTH, LIMIT; ports clk, i_sclr, i_clr, i_en, o_expired). It is instantiated once and cleared on every WAIT-state entry.

Test Plan:
(bench uses TIMEOUT_CYCLES=100, MAX_RETRY=2, i_tx_ready=1 unless noted)
- After reset, i_leds=3'b100 → o_tx_en with 8'hED; send FA → o_tx_en with 8'h04; send FA → o_leds_applied=3'b100, o_busy=0, o_err=0; neither FA appears on o_byte_en.
- In WAIT_ACK1, send 8'h1C then 8'hFA → o_byte_en pulses once with o_byte=8'h1C one cycle after its strobe; the sequence proceeds to ARG.
- In WAIT_ACK2, reply FE, FE, FA → 8'h04 is transmitted three times in total; the update succeeds.
- Send no ack after 8'hED → ED is retransmitted after 100 cycles, 3 transmissions in total, then o_err=1, o_leds_applied=000, no further tx while i_leds is unchanged; changing i_leds to 3'b010 starts a new sequence.
- Hold i_tx_ready=0 for 500 cycles in CMD → no o_tx_en and no timeout; ED is sent on the cycle after i_tx_ready rises.
- Change i_leds mid-sequence from 100 to 110 → the first sequence sends 8'h04; once it completes, a second sequence sends ED then 8'h06.
- Assert i_sclr while in WAIT_ACK2 → the next cycle shows o_busy=0, o_leds_applied=000; a new sequence starts after release.
